// File: rtl/uart_div_ctrl_if.sv
// Byte-stream handshake between the divider and the UART RX/TX engines.
interface uart_div_ctrl_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;

  modport master (output rx_valid, rx_data, tx_ready, input tx_valid, tx_data);
  modport slave  (input rx_valid, rx_data, tx_ready, output tx_valid, tx_data);
endinterface

// File: rtl/uart_div_ctrl.sv
// Collects a dividend/divisor frame from UART RX, runs a W-cycle restoring
// division and streams quotient then remainder back out through UART TX.
module uart_div_ctrl #(
  parameter int OP_BYTES    = 2,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_div_ctrl_if.slave        bus,
  output logic [8*OP_BYTES-1:0] result_led,
  output logic                  busy,
  output logic                  err_div0,
  output logic                  timeout_err
);
  localparam int W   = 8 * OP_BYTES;
  localparam int NB  = 2 * OP_BYTES;
  localparam int BCW = $clog2(NB);
  localparam int DCW = $clog2(W);
  localparam int ICW = $clog2(TIMEOUT_CYC) + 1;

  typedef enum logic [1:0] {IDLE, RX, DIV, TX} state_t;

  state_t         state_reg;
  logic [2*W-1:0] frame_reg;
  logic [2*W-1:0] frame_next;
  logic [2*W-1:0] resp_reg;
  logic [BCW-1:0] byte_cnt_reg;
  logic [BCW-1:0] tx_cnt_reg;
  logic [ICW-1:0] idle_cnt_reg;
  logic [DCW-1:0] div_cnt_reg;
  logic [W-1:0]   rem_reg;
  logic [W-1:0]   quo_reg;
  logic [W-1:0]   rem_next;
  logic [W-1:0]   quo_next;
  logic [W-1:0]   dividend;
  logic [W-1:0]   divisor;
  logic [W-1:0]   q_final;
  logic [W-1:0]   r_final;
  logic [W:0]     trial;
  logic [W:0]     diff;

  // Frame bytes shift in from the top so the first byte ends up in bit 0.
  // quo_reg starts as the dividend and shifts its bits out MSB first while
  // quotient bits shift in at the bottom.
  always_comb begin
    frame_next = {bus.rx_data, frame_reg[2*W-1:8]};
    dividend   = frame_reg[W-1:0];
    divisor    = frame_reg[2*W-1:W];
    trial      = {rem_reg, quo_reg[W-1]};
    diff       = trial - {1'b0, divisor};
    rem_next   = diff[W] ? trial[W-1:0] : diff[W-1:0];
    quo_next   = {quo_reg[W-2:0], ~diff[W]};
    q_final    = (divisor == '0) ? '1 : quo_next;
    r_final    = (divisor == '0) ? dividend : rem_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      frame_reg    <= '0;
      resp_reg     <= '0;
      byte_cnt_reg <= '0;
      tx_cnt_reg   <= '0;
      idle_cnt_reg <= '0;
      div_cnt_reg  <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      bus.tx_valid <= 1'b0;
      bus.tx_data  <= '0;
      result_led   <= '0;
      busy         <= 1'b0;
      err_div0     <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.rx_valid) begin
            frame_reg    <= {bus.rx_data, {(2*W-8){1'b0}}};
            byte_cnt_reg <= BCW'(1);
            idle_cnt_reg <= '0;
            err_div0     <= 1'b0;
            timeout_err  <= 1'b0;
            busy         <= 1'b1;
            state_reg    <= RX;
          end
        end
        RX: begin
          if (bus.rx_valid) begin
            frame_reg    <= frame_next;
            idle_cnt_reg <= '0;
            if (byte_cnt_reg == BCW'(NB-1)) begin
              byte_cnt_reg <= '0;
              quo_reg      <= frame_next[W-1:0];
              rem_reg      <= '0;
              div_cnt_reg  <= '0;
              state_reg    <= DIV;
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 1'b1;
            end
          end else if (idle_cnt_reg == ICW'(TIMEOUT_CYC-1)) begin
            frame_reg    <= '0;
            byte_cnt_reg <= '0;
            idle_cnt_reg <= '0;
            timeout_err  <= 1'b1;
            busy         <= 1'b0;
            state_reg    <= IDLE;
          end else begin
            idle_cnt_reg <= idle_cnt_reg + 1'b1;
          end
        end
        DIV: begin
          // A zero divisor still runs all W steps so latency never depends on data.
          rem_reg     <= rem_next;
          quo_reg     <= quo_next;
          div_cnt_reg <= div_cnt_reg + 1'b1;
          if (div_cnt_reg == DCW'(W-1)) begin
            result_led <= q_final;
            resp_reg   <= {r_final, q_final};
            err_div0   <= (divisor == '0);
            tx_cnt_reg <= '0;
            state_reg  <= TX;
          end
        end
        TX: begin
          // The first TX cycle only presents byte 0, giving the W+1 cycle latency.
          if (!bus.tx_valid) begin
            bus.tx_valid <= 1'b1;
            bus.tx_data  <= resp_reg[7:0];
          end else if (bus.tx_ready) begin
            if (tx_cnt_reg == BCW'(NB-1)) begin
              bus.tx_valid <= 1'b0;
              busy         <= 1'b0;
              state_reg    <= IDLE;
            end else begin
              tx_cnt_reg  <= tx_cnt_reg + 1'b1;
              resp_reg    <= {8'h00, resp_reg[2*W-1:8]};
              bus.tx_data <= resp_reg[15:8];
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_div_ctrl.md
Name: uart_div_ctrl

Overview:
- Sits between the UART RX/TX byte engines in the same datapath.
- Receives a frame carrying an N-byte dividend and an N-byte divisor, then runs a sequential restoring division.
- Returns quotient and remainder as a 2N-byte response through a valid/ready handshake.
- Parametrised in operand width and adds divide-by-zero handling, an inter-byte timeout, TX back-pressure and a busy/status interface.

Parameters:
- OP_BYTES, 2, bytes per operand; operand width W = 8*OP_BYTES (localparam), legal range 1..4.
- TIMEOUT_CYC, 5000000, maximum idle cycles between two RX bytes of one frame before the frame is discarded.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- tx_ready  in  1  UART TX can accept a byte this cycle.
- tx_valid  out  1  tx_data holds a byte to send.
- tx_data  out  8  byte to send.
- result_led  out  W  last computed quotient, for LED display.
- busy  out  1  high in every state other than IDLE.
- err_div0  out  1  last completed frame had divisor 0.
- timeout_err  out  1  last frame was aborted by timeout.

Behaviour:
- Reset, applied synchronously at any state including mid-DIV or mid-TX:
  - state IDLE.
  - tx_valid=0, tx_data=0, result_led=0, busy=0, err_div0=0, timeout_err=0.
  - Byte counters, idle counter and operands all cleared.
- Frame format: 2*OP_BYTES bytes, each operand LSB first. Dividend A comes first, then divisor B.
- Response format: quotient Q then remainder R, each OP_BYTES bytes, LSB first. 2*OP_BYTES bytes total.
- States:
  - IDLE: rx_valid stores the byte into A[7:0], byte count = 1, goes to RX. That same edge clears err_div0 and timeout_err.
  - RX: each rx_valid stores the byte at the next position and resets the idle counter.
    - Otherwise the idle counter increments.
    - When the byte completing B is accepted, go to DIV at that edge.
    - If the idle counter reaches TIMEOUT_CYC-1 without rx_valid: set timeout_err=1, discard partial operands, go to IDLE.
    - When OP_BYTES=1 the frame completes on its 2nd byte.
  - DIV: restoring division, one quotient bit per cycle, MSB first, exactly W cycles.
    - Partial remainder is W+1 bits.
    - On the last cycle: result_led<=Q and go to TX.
    - If B==0, still spend W cycles. Force Q=all ones and R=A, and set err_div0=1 on the exit edge.
  - TX: tx_valid=1 and tx_data=current response byte.
    - A byte is transferred on an edge where tx_valid&&tx_ready; tx_data advances on that edge.
    - tx_data and tx_valid stay stable while tx_ready=0.
    - After the last byte transfers, tx_valid=0 and the state returns to IDLE.
- Latency: tx_valid first rises exactly W+1 cycles after the clock edge that accepted the last RX byte. This holds independent of operand values, including divide by zero.
- rx_valid during DIV or TX is ignored (byte dropped) and does not start a new frame.
- rx_valid in the same cycle that returns to IDLE is also dropped.
- Status flags (err_div0, timeout_err) are sticky until the first byte of the next frame or reset.
- No timeout in DIV or TX; TX waits on tx_ready indefinitely.
- Width rules:
  - Operands unsigned.
  - R<B always when B≠0.
  - Q*B+R==A exactly.

Test Plan:
- OP_BYTES=2, rx E8 03 07 00 (1000/7), tx_ready=1 -> tx 8E 00 06 00, result_led=0x008E, err_div0=0, tx_valid rises 17 cycles after the last rx_valid.
- Divide by zero, rx E8 03 00 00 -> tx FF FF E8 03, err_div0=1 after DIV, cleared on the next frame's first byte; same 17-cycle latency.
- Back-pressure, rx 10 00 03 00 with tx_ready held 0 for 10 cycles before each byte -> tx 05 00 01 00 with no byte repeated or skipped; tx_data constant while stalled.
- Timeout, TIMEOUT_CYC=100: rx E8 03, then silence -> timeout_err=1 and busy=0 exactly 100 cycles after the 2nd byte. A following full frame 64 00 0A 00 -> tx 0A 00 00 00 and timeout_err cleared.
- Reset mid-TX: assert rst for 1 cycle after the 2nd response byte -> next cycle all outputs are at reset values. A fresh frame FF FF 01 00 -> tx FF FF 00 00.
- OP_BYTES=4, rx 00 00 00 80 03 00 00 00 (2147483648/3) -> tx AA AA AA 2A 02 00 00 00; tx_valid 33 cycles after the last byte; bytes sent during DIV are ignored.
